meas_sched: RTL and testbench
=============================

MEAS_SCHED -- requirements
Module: meas_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesting qubit channels.
REQ-002 Parameter TIMEOUT, default 4096: maximum number of cycles to wait for meas_done after issue.
REQ-003 Parameter TW, default 13: timeout counter width; TW SHALL be at least $clog2(TIMEOUT+1).
REQ-004 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port req_valid, input, NREQ: per-channel request for a measurement.
REQ-007 Port req_cmd, input, 64*NREQ: per-channel 64-bit measurement command; channel i is bits [64*i+:64].
REQ-008 Port req_ready, output, NREQ: one-hot grant; a transfer occurs when req_valid[i]&req_ready[i].
REQ-009 Port cmd, output, 64: command to the measurement block.
REQ-010 Port cstrobe, output, 1: one-cycle command strobe to the measurement block.
REQ-011 Port meas_active, input, 1: measurement block busy.
REQ-012 Port meas_done, input, 1: one-cycle measurement-complete pulse.
REQ-013 Port meas_resultx, input, 1: discriminated I-axis result.
REQ-014 Port meas_resulty, input, 1: discriminated Q-axis result.
REQ-015 Port meas_xacc, input, 32 signed: rotated accumulator value.
REQ-016 Port res_valid, output, NREQ: one-hot, one-cycle result pulse to the owning channel.
REQ-017 Port res_x, output, 1: I-axis result bit; res_y, output, 1: Q-axis result bit.
REQ-018 Port res_acc, output, 32: accumulator value; res_err, output, 1: timeout flag; all four are qualified by res_valid.
REQ-019 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, RESULT.
REQ-021 IDLE grant condition: meas_active==0 and any req_valid; req_ready is combinational and one-hot at the round-robin winner.
- Otherwise req_ready is all zero.
REQ-022 Round-robin search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so channel 0 has first priority.
REQ-023 On a transfer at cycle T:
- owner index and req_cmd slice are registered;
- last_grant is updated;
- FSM goes to ISSUE.
REQ-024 In ISSUE (cycle T+1): cmd holds the captured command, cstrobe=1 for exactly this cycle, FSM goes to WAIT.
REQ-025 cmd SHALL hold its value until the next issue; cstrobe is 0 in every other state.
REQ-026 In WAIT, a 1-cycle timeout counter starts at 0 on entry and increments each cycle.
REQ-027 meas_done in WAIT at cycle D: res_x, res_y and res_acc capture the inputs, res_err<=0, FSM goes to RESULT.
REQ-028 Timeout: if the counter reaches TIMEOUT-1 without meas_done, res_err<=1, res_acc<=0, res_x<=0, res_y<=0, FSM goes to RESULT.
REQ-029 meas_done on the same cycle as the timeout: done wins and res_err=0.
REQ-030 In RESULT (cycle D+1): res_valid[owner]=1 for one cycle, then FSM goes to IDLE.
- The earliest next grant is at D+2, subject to meas_active==0.
REQ-031 res_x, res_y, res_acc and res_err hold until the next RESULT.
REQ-032 meas_done outside WAIT is ignored; it causes no state change and no res_valid.
REQ-033 req_valid deasserted before a grant is simply not served; there is no queuing inside this block.
REQ-034 meas_active high while in IDLE blocks all grants, including to a requester that is already waiting.
REQ-035 The counter saturates at TIMEOUT-1; it never wraps.

Reset
REQ-036 While reset is high, all outputs are 0:
- FSM=IDLE, req_ready=0, cstrobe=0, cmd=0, res_valid=0, res_x=0, res_y=0, res_acc=0, res_err=0, busy=0;
- counter=0, last_grant=NREQ-1.
REQ-037 Reset asserted mid-operation (any state) aborts the operation immediately; no res_valid is issued for the aborted request.
REQ-038 After reset deassertion, the first grant can occur on the first clock edge.

Verification
REQ-039 Single request: req_valid[2]=1, req_cmd[2]=64'h0123_4567_89AB_CDEF, meas_done 10 cycles after cstrobe with resultx=1, resulty=0, xacc=-5.
- Required: ready[2] at T; cstrobe and cmd=0x0123456789ABCDEF at T+1;
- res_valid=4'b0100 one cycle after done, with res_x=1, res_y=0, res_acc=32'hFFFF_FFFB, res_err=0.
REQ-040 Fairness: all four req_valid held high, and each measurement completes.
- Required: grant order 0,1,2,3,0, and each channel's res_valid matches its own grant.
REQ-041 Timeout with TIMEOUT=16 and no meas_done.
- Required: res_valid on the owner with res_err=1, res_acc=0, exactly 17 cycles after cstrobe;
- the FSM is back in IDLE the next cycle.
REQ-042 Collision and blocking:
- meas_done on the final timeout cycle yields res_err=0;
- meas_active=1 while req_valid=1 keeps req_ready=0 until meas_active falls.
REQ-043 Reset pulse during WAIT:
- Required: all outputs return to 0 asynchronously, and no res_valid follows;
- a new request after reset is granted to channel 0 first.

Source files
------------

// File: rtl/meas_sched.sv
// meas_sched: round-robin scheduler sharing one measurement block among NREQ
// qubit channels. A granted command is issued with a one-cycle strobe, the
// result (or a timeout) is returned to the owning channel as a one-cycle pulse.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_cmd     per-channel request and 64-bit command
//   req_ready             one-hot combinational grant (IDLE only)
//   cmd/cstrobe           command and one-cycle strobe to the measurement block
//   meas_active           measurement block busy (blocks grants)
//   meas_done             one-cycle completion pulse, with meas_result*/meas_xacc
//   res_valid             one-hot result pulse to the owning channel
//   res_x/res_y/res_acc   captured results; res_err flags a timeout
//   busy                  high whenever the FSM is not idle
module meas_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TW      = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [64*NREQ-1:0]     req_cmd,
  output logic [NREQ-1:0]        req_ready,
  output logic [63:0]            cmd,
  output logic                   cstrobe,
  input  logic                   meas_active,
  input  logic                   meas_done,
  input  logic                   meas_resultx,
  input  logic                   meas_resulty,
  input  logic signed [31:0]     meas_xacc,
  output logic [NREQ-1:0]        res_valid,
  output logic                   res_x,
  output logic                   res_y,
  output logic [31:0]            res_acc,
  output logic                   res_err,
  output logic                   busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResult} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, last_q;
  logic [63:0]     cmd_q;
  logic [TW-1:0]   cnt_q;
  logic            res_x_q, res_y_q, res_err_q;
  logic [31:0]     res_acc_q;

  logic            grant_any;
  logic [IW-1:0]   grant_idx;
  logic            transfer;
  logic            timed_out;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[(32'(last_q) + 32'd1 + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = IW'((32'(last_q) + 32'd1 + k) % NREQ);
      end
    end
  end

  // Gated by reset so the grant is zero while reset is held.
  assign req_ready = (state_q == StIdle && !meas_active && grant_any && !reset) ?
                     (NREQ'(1) << grant_idx) : '0;
  assign transfer  = |(req_valid & req_ready);
  assign timed_out = (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (transfer) state_d = StIssue;
      StIssue:  state_d = StWait;
      StWait:   if (meas_done || timed_out) state_d = StResult;
      StResult: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      last_q    <= IW'(NREQ - 1);
      cmd_q     <= '0;
      cnt_q     <= '0;
      res_x_q   <= 1'b0;
      res_y_q   <= 1'b0;
      res_acc_q <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        owner_q <= grant_idx;
        last_q  <= grant_idx;
        cmd_q   <= req_cmd[64*grant_idx +: 64];
      end
      // Counter is zero on WAIT entry and saturates at TIMEOUT-1.
      if (state_q == StWait) begin
        if (!timed_out) cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (state_q == StWait) begin
        // A done on the final timeout cycle takes precedence.
        if (meas_done) begin
          res_x_q   <= meas_resultx;
          res_y_q   <= meas_resulty;
          res_acc_q <= meas_xacc;
          res_err_q <= 1'b0;
        end else if (timed_out) begin
          res_x_q   <= 1'b0;
          res_y_q   <= 1'b0;
          res_acc_q <= '0;
          res_err_q <= 1'b1;
        end
      end
    end
  end

  assign cmd       = cmd_q;
  assign cstrobe   = (state_q == StIssue);
  assign res_valid = (state_q == StResult) ? (NREQ'(1) << owner_q) : '0;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_acc   = res_acc_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_meas_sched.sv
// Testbench for meas_sched (NREQ=4, TIMEOUT=16): table of transactions with a
// result scoreboard, plus hand sequences for reset, stray done and abort.
module tb_meas_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TO   = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [64*NREQ-1:0]  req_cmd;
  logic [NREQ-1:0]     req_ready;
  logic [63:0]         cmd;
  logic                cstrobe;
  logic                meas_active, meas_done, meas_resultx, meas_resulty;
  logic [31:0]         meas_xacc;
  logic [NREQ-1:0]     res_valid;
  logic                res_x, res_y, res_err, busy;
  logic [31:0]         res_acc;

  meas_sched #(.NREQ(NREQ), .TIMEOUT(TO), .TW(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .cmd(cmd), .cstrobe(cstrobe), .meas_active(meas_active),
    .meas_done(meas_done), .meas_resultx(meas_resultx), .meas_resulty(meas_resulty),
    .meas_xacc(meas_xacc), .res_valid(res_valid), .res_x(res_x), .res_y(res_y),
    .res_acc(res_acc), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    int          owner;
    int          active;  // cycles meas_active is held high first
    int          delay;   // cycles from cstrobe to done; 0 = no done (timeout)
    logic        in_x, in_y;
    logic [31:0] in_acc;
  } vec_t;

  typedef struct {
    logic [3:0]  mask;
    logic        x, y, err;
    logic [31:0] acc;
  } res_t;

  vec_t vt[11];
  res_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] cmd_of(input int vi, input int ch);
    return 64'h0123_4567_89AB_CDEF ^ {32'(vi), 32'(ch ^ 2)};
  endfunction

  // Scoreboard: every result pulse must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (res_valid !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_res_valid", 64'(res_valid), 64'h0);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("res_valid", 64'(res_valid), 64'(e.mask));
        check("res_x", 64'(res_x), 64'(e.x));
        check("res_y", 64'(res_y), 64'(e.y));
        check("res_acc", 64'(res_acc), 64'(e.acc));
        check("res_err", 64'(res_err), 64'(e.err));
      end
    end
  end

  task automatic run_vec(input int vi);
    vec_t v;
    res_t e;
    logic [3:0] m;
    bit g;
    int w;
    v = vt[vi];
    m = 4'(1) << v.owner;
    for (int ch = 0; ch < NREQ; ch++) req_cmd[64*ch +: 64] = cmd_of(vi, ch);
    req_valid    = v.req;
    meas_resultx = v.in_x;
    meas_resulty = v.in_y;
    meas_xacc    = v.in_acc;
    meas_active  = (v.active != 0);
    for (int a = 0; a < v.active; a++) begin
      #1 check("blocked_by_active", 64'(req_ready), 64'h0);
      @(negedge clk);
    end
    meas_active = 1'b0;
    g = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready != '0) begin
        g = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!g) begin
      check("grant_timeout", 64'(req_ready), 64'(m));
      return;
    end
    check("grant", 64'(req_ready), 64'(m));
    e.mask = m;
    e.err  = (v.delay == 0);
    e.x    = e.err ? 1'b0 : v.in_x;
    e.y    = e.err ? 1'b0 : v.in_y;
    e.acc  = e.err ? 32'h0 : v.in_acc;
    sb.push_back(e);
    @(negedge clk);
    #1 check("cstrobe", 64'(cstrobe), 64'h1);
    check("cmd", cmd, cmd_of(vi, v.owner));
    w = (v.delay == 0) ? int'(TO) : v.delay;
    repeat (w) @(negedge clk);
    if (v.delay != 0) meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    #1 check("res_timing", 64'(res_valid), 64'(m));
    check("cstrobe_low", 64'(cstrobe), 64'h0);
    check("cmd_hold", cmd, cmd_of(vi, v.owner));
    @(negedge clk);
    #1 check("idle_after_result", 64'(busy), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{4'b0100, 2, 0, 10, 1'b1, 1'b0, 32'hFFFF_FFFB};
    vt[1]  = '{4'b1000, 3, 0, 0,  1'b1, 1'b1, 32'h0000_1234};
    vt[2]  = '{4'b1111, 0, 0, 3,  1'b0, 1'b1, 32'h7FFF_FFFF};
    vt[3]  = '{4'b1111, 1, 0, 16, 1'b1, 1'b1, 32'h8000_0000};
    vt[4]  = '{4'b1111, 2, 0, 5,  1'b1, 1'b0, 32'h0000_0042};
    vt[5]  = '{4'b1111, 3, 0, 0,  1'b1, 1'b0, 32'h0000_DEAD};
    vt[6]  = '{4'b1111, 0, 2, 2,  1'b0, 1'b0, 32'h0000_0007};
    vt[7]  = '{4'b1010, 1, 3, 4,  1'b0, 1'b1, 32'hFFFF_0000};
    vt[8]  = '{4'b1010, 3, 0, 1,  1'b1, 1'b1, 32'h0000_0005};
    vt[9]  = '{4'b0101, 0, 0, 7,  1'b0, 1'b1, 32'h0000_0100};
    vt[10] = '{4'b0110, 1, 0, 2,  1'b1, 1'b1, 32'h0000_CAFE};

    reset = 1'b1;
    req_valid = 4'b0100;
    req_cmd = '0;
    meas_active = 1'b0;
    meas_done = 1'b0;
    meas_resultx = 1'b0;
    meas_resulty = 1'b0;
    meas_xacc = '0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_cstrobe", 64'(cstrobe), 64'h0);
    check("rst_cmd", cmd, 64'h0);
    check("rst_res_valid", 64'(res_valid), 64'h0);
    check("rst_res_bits", 64'({res_x, res_y, res_err}), 64'h0);
    check("rst_res_acc", 64'(res_acc), 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("first_grant_after_reset", 64'(req_ready), 64'h4);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Stray done in IDLE must be ignored.
    req_valid = '0;
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    #1 check("stray_done_busy", 64'(busy), 64'h0);
    check("stray_done_res_valid", 64'(res_valid), 64'h0);

    // Reset during WAIT aborts without a result; channel 0 has priority after.
    req_valid = 4'b1000;
    #1 check("abort_grant", 64'(req_ready), 64'h8);
    repeat (4) @(negedge clk);
    #1 check("abort_busy_before", 64'(busy), 64'h1);
    reset = 1'b1;
    #1 check("abort_busy", 64'(busy), 64'h0);
    check("abort_cmd", cmd, 64'h0);
    check("abort_res_bits", 64'({res_x, res_y, res_err}), 64'h0);
    check("abort_res_acc", 64'(res_acc), 64'h0);
    check("abort_req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    repeat (TO + 4) @(negedge clk);
    req_valid = 4'b1111;
    #1 check("post_abort_grant", 64'(req_ready), 64'h1);
    check("sb_empty", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
